// File: rtl/iic_cmd_queue.sv
// IIC command queue: buffers {dev, reg, data} write commands in a FIFO
// and issues them one at a time to the downstream IIC write stage.
//
// Ports:
//   sys_clk, sys_reset          clock, synchronous active-high reset
//   cmd_valid / cmd_ready       producer handshake (cmd_ready registered)
//   cmd_dev_addr/reg_addr/data  command fields
//   iic_send_en                 one-cycle start pulse to the write stage
//   iic_device_addr/send_addr/send_data  latched command to the write stage
//   busy                        FIFO non-empty or transaction/gap running
//   fifo_level                  current FIFO occupancy
//   overflow                    sticky rejected-push flag
//
// Build option: define IIC_CMD_QUEUE_OVF_FLAG_EN to enable the sticky
// overflow flag; otherwise overflow is tied to 0.

module iic_cmd_queue #(
    parameter int DEPTH       = 8,
    parameter int XFER_CYCLES = 32,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_dev_addr,
    input  logic [7:0]             cmd_reg_addr,
    input  logic [7:0]             cmd_data,
    output logic                   iic_send_en,
    output logic [6:0]             iic_device_addr,
    output logic [7:0]             iic_send_addr,
    output logic [7:0]             iic_send_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(XFER_CYCLES + GAP_CYCLES + 2);

    localparam logic [CW-1:0] XFER_LAST =
        CW'(XFER_CYCLES > 0 ? XFER_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST =
        CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    logic [22:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_ready;
    logic          r_ne_q;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [6:0]    r_dev;
    logic [7:0]    r_reg;
    logic [7:0]    r_dat;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;
    logic [22:0]   w_head;

    assign w_push = cmd_valid && r_ready;
    assign w_head = r_mem[r_rd_ptr];

    // Storage has no reset: contents are meaningless while the level is 0.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_dev_addr, cmd_reg_addr, cmd_data};
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
            r_ne_q   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            // Ready looks at the next level so a full FIFO never accepts.
            r_ready <= (w_level_nxt < LW'(DEPTH));
            // Delayed non-empty: an entry must sit in the FIFO one full
            // cycle before it may be issued.
            r_ne_q  <= (r_level != '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ne_q && (r_level != '0)) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = XFER_LAST;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = GAP_LAST;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dev   <= '0;
            r_reg   <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pop) begin
                {r_dev, r_reg, r_dat} <= w_head;
            end
        end
    end

`ifdef IIC_CMD_QUEUE_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_ovf <= 1'b0;
        end else if (cmd_valid && !r_ready) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    assign cmd_ready       = r_ready;
    assign fifo_level      = r_level;
    assign iic_send_en     = (r_state == S_ISSUE);
    assign iic_device_addr = r_dev;
    assign iic_send_addr   = r_reg;
    assign iic_send_data   = r_dat;
    assign busy            = (r_level != '0) || (r_state != S_IDLE);

endmodule

// File: tb/tb_iic_cmd_queue.sv
// Self-checking bench for iic_cmd_queue: two instances (gap 4 and gap 0)
// driven in lockstep and compared against a timeline reference model.

module tb_iic_cmd_queue;

    localparam int DEPTH = 8;
    localparam int XFER  = 32;
    localparam int LW    = 4;
    localparam int MQ    = 8192;
    localparam int EVN   = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [7:0]  dat;

    logic          o_rdy  [2];
    logic          o_en   [2];
    logic [6:0]    o_dev  [2];
    logic [7:0]    o_reg  [2];
    logic [7:0]    o_dat  [2];
    logic          o_busy [2];
    logic [LW-1:0] o_lvl  [2];
    logic          o_ovf  [2];

    iic_cmd_queue #(.DEPTH(DEPTH), .XFER_CYCLES(XFER), .GAP_CYCLES(4)) u_dut0 (
        .sys_clk(clk), .sys_reset(rst), .cmd_valid(valid),
        .cmd_ready(o_rdy[0]), .cmd_dev_addr(dev), .cmd_reg_addr(rg),
        .cmd_data(dat), .iic_send_en(o_en[0]),
        .iic_device_addr(o_dev[0]), .iic_send_addr(o_reg[0]),
        .iic_send_data(o_dat[0]), .busy(o_busy[0]),
        .fifo_level(o_lvl[0]), .overflow(o_ovf[0])
    );

    iic_cmd_queue #(.DEPTH(DEPTH), .XFER_CYCLES(XFER), .GAP_CYCLES(0)) u_dut1 (
        .sys_clk(clk), .sys_reset(rst), .cmd_valid(valid),
        .cmd_ready(o_rdy[1]), .cmd_dev_addr(dev), .cmd_reg_addr(rg),
        .cmd_data(dat), .iic_send_en(o_en[1]),
        .iic_device_addr(o_dev[1]), .iic_send_addr(o_reg[1]),
        .iic_send_data(o_dat[1]), .busy(o_busy[1]),
        .fifo_level(o_lvl[1]), .overflow(o_ovf[1])
    );

    int gap_of [2] = '{4, 0};

`ifdef IIC_CMD_QUEUE_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference model: a command pushed at edge P issues at edge
    // max(P+2, previous issue + 2+XFER+GAP); busy covers the issue edge
    // through XFER+GAP edges later.
    logic [22:0] mq [2][MQ];
    int          mt [2][MQ];
    int          mh [2];
    int          mtl [2];
    int          last_i [2];
    bit          have [2];
    bit          m_ready [2];
    bit          m_en [2];
    bit          m_ovf [2];
    bit          m_busy [2];
    logic [22:0] m_out [2];
    int          m_level [2];

    int          ev_n [2];
    int          ev_t [2][EVN];
    logic [22:0] ev_c [2][EVN];

    task automatic model_edge(input int k, input bit r, input bit v,
                              input logic [22:0] c, input int e);
        bit pop;
        bit acc;
        if (r) begin
            mh[k] = 0; mtl[k] = 0; have[k] = 0; m_en[k] = 0;
            m_out[k] = '0; m_ovf[k] = 0; m_ready[k] = 1;
            m_busy[k] = 0; m_level[k] = 0;
            return;
        end
        pop = (mtl[k] > mh[k]) && (e >= mt[k][mh[k]] + 2) &&
              (!have[k] || e >= last_i[k] + 2 + XFER + gap_of[k]);
        acc = v && m_ready[k];
        if (OVF_EN && v && !m_ready[k]) m_ovf[k] = 1;
        m_en[k] = pop;
        if (pop) begin
            m_out[k] = mq[k][mh[k]];
            mh[k]++;
            last_i[k] = e;
            have[k] = 1;
        end
        if (acc && mtl[k] < MQ) begin
            mq[k][mtl[k]] = c;
            mt[k][mtl[k]] = e;
            mtl[k]++;
        end
        m_level[k] = mtl[k] - mh[k];
        m_ready[k] = m_level[k] < DEPTH;
        m_busy[k]  = (m_level[k] > 0) ||
                     (have[k] && e <= last_i[k] + XFER + gap_of[k]);
    endtask

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d edge %0d: got %0h expected %0h",
                         nm, k, edge_n, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [22:0] c);
        rst = r;
        valid = v;
        {dev, rg, dat} = c;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, r, v, c, edge_n);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("en",    k, 32'(o_en[k]),   32'(m_en[k]));
            chk("dev",   k, 32'(o_dev[k]),  32'(m_out[k][22:16]));
            chk("reg",   k, 32'(o_reg[k]),  32'(m_out[k][15:8]));
            chk("data",  k, 32'(o_dat[k]),  32'(m_out[k][7:0]));
            chk("busy",  k, 32'(o_busy[k]), 32'(m_busy[k]));
            chk("level", k, 32'(o_lvl[k]),  32'(m_level[k]));
            chk("ready", k, 32'(o_rdy[k]),  32'(m_ready[k]));
            chk("ovf",   k, 32'(o_ovf[k]),  32'(m_ovf[k]));
            if (o_en[k] === 1'b1 && ev_n[k] < EVN) begin
                ev_t[k][ev_n[k]] = edge_n;
                ev_c[k][ev_n[k]] = {o_dev[k], o_reg[k], o_dat[k]};
                ev_n[k]++;
            end
        end
        edge_n++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        ev_n[0] = 0;
        ev_n[1] = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    function automatic logic [22:0] mk(input int i);
        return {7'(i + 1), 8'(i * 7 + 3), 8'(8'hF0 ^ 8'(i))};
    endfunction

    typedef struct {
        bit          v;
        logic [22:0] c;
        bit          x_en;
        int          x_lvl;
        bit          x_busy;
        bit          x_rdy;
        logic [22:0] x_out;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int base;
        int pushed;
        int budget;
        int busy_edge [2];
        int pulses;

        tbl[0] = '{1, {7'h50, 8'h12, 8'hA5}, 0, 1, 1, 1, 23'h0};
        tbl[1] = '{0, 23'h0,                 0, 1, 1, 1, 23'h0};
        tbl[2] = '{0, 23'h0,                 1, 0, 1, 1, {7'h50, 8'h12, 8'hA5}};
        tbl[3] = '{1, {7'h11, 8'h22, 8'h33}, 0, 1, 1, 1, {7'h50, 8'h12, 8'hA5}};
        tbl[4] = '{1, {7'h44, 8'h55, 8'h66}, 0, 2, 1, 1, {7'h50, 8'h12, 8'hA5}};
        tbl[5] = '{0, 23'h0,                 0, 2, 1, 1, {7'h50, 8'h12, 8'hA5}};

        rst = 1'b1; valid = 1'b0; dev = '0; rg = '0; dat = '0;
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mtl[k] = 0; ev_n[k] = 0;
        end

        // Reset values
        do_reset();
        chk("rst_en",    0, 32'(o_en[0]),   0);
        chk("rst_rdy",   0, 32'(o_rdy[0]),  1);
        chk("rst_busy",  0, 32'(o_busy[0]), 0);
        chk("rst_lvl",   0, 32'(o_lvl[0]),  0);
        chk("rst_ovf",   0, 32'(o_ovf[0]),  0);

        // Table-driven first-command sequence
        for (int i = 0; i < 6; i++) begin
            step(1'b0, tbl[i].v, tbl[i].c);
            chk("tbl_en",   0, 32'(o_en[0]),   32'(tbl[i].x_en));
            chk("tbl_lvl",  0, 32'(o_lvl[0]),  32'(tbl[i].x_lvl));
            chk("tbl_busy", 0, 32'(o_busy[0]), 32'(tbl[i].x_busy));
            chk("tbl_rdy",  0, 32'(o_rdy[0]),  32'(tbl[i].x_rdy));
            chk("tbl_out",  0, {o_dev[0], o_reg[0], o_dat[0]},
                32'(tbl[i].x_out));
        end
        idle(120);

        // Single push: busy falls 37 cycles after the pulse
        do_reset();
        base = edge_n;
        step(1'b0, 1'b1, {7'h50, 8'h12, 8'hA5});
        busy_edge[0] = -1;
        busy_edge[1] = -1;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, '0);
            for (int k = 0; k < 2; k++)
                if (busy_edge[k] < 0 && o_busy[k] === 1'b0)
                    busy_edge[k] = edge_n - 1 - base;
        end
        chk("busy_drop", 0, busy_edge[0], 39);
        chk("busy_drop", 1, busy_edge[1], 35);
        chk("single_en_t", 0, ev_t[0][0] - base, 2);

        // Three back-to-back pushes: spacing 38 / 34, order kept
        do_reset();
        base = edge_n;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(i));
        idle(130);
        for (int k = 0; k < 2; k++) begin
            chk("b2b_cnt", k, ev_n[k], 3);
            for (int i = 0; i < 3 && i < ev_n[k]; i++) begin
                chk("b2b_t", k, ev_t[k][i] - base,
                    2 + i * (k == 0 ? 38 : 34));
                chk("b2b_c", k, 32'(ev_c[k][i]), 32'(mk(i)));
            end
        end

        // Push and pop on the same edge at level 3
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mk(i + 10));
        chk("lvl3_pre", 0, 32'(o_lvl[0]), 3);
        idle(36);
        step(1'b0, 1'b1, mk(20));
        chk("pp_en",  0, 32'(o_en[0]),  1);
        chk("pp_lvl", 0, 32'(o_lvl[0]), 3);
        idle(200);

        // Reset during a transaction with 2 commands queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(i + 30));
        idle(8);
        chk("mid_lvl", 0, 32'(o_lvl[0]), 2);
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            chk("abort_en",   k, 32'(o_en[k]),   0);
            chk("abort_out",  k, {o_dev[k], o_reg[k], o_dat[k]}, 0);
            chk("abort_busy", k, 32'(o_busy[k]), 0);
            chk("abort_lvl",  k, 32'(o_lvl[k]),  0);
            chk("abort_rdy",  k, 32'(o_rdy[k]),  1);
            chk("abort_ovf",  k, 32'(o_ovf[k]),  0);
        end
        ev_n[0] = 0;
        ev_n[1] = 0;
        idle(150);
        chk("abort_pulses", 0, ev_n[0] + ev_n[1], 0);

        // Ten pushes into a draining queue
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, mk(i + 40));
            if (i == 8) begin
                chk("full_lvl", 0, 32'(o_lvl[0]), 8);
                chk("full_rdy", 0, 32'(o_rdy[0]), 0);
            end
        end
        chk("ovf_flag", 0, 32'(o_ovf[0]), 32'(OVF_EN));
        idle(400);
        chk("fill_cnt", 0, ev_n[0], 9);
        for (int i = 0; i < 9 && i < ev_n[0]; i++)
            chk("fill_ord", 0, 32'(ev_c[0][i]), 32'(mk(i + 40)));

        // Gap 0: 20 pushes wrap the pointers, period 34
        do_reset();
        pushed = 0;
        budget = 0;
        while (pushed < 20 && budget < 2000) begin
            if (m_ready[1]) begin
                step(1'b0, 1'b1, mk(pushed + 60));
                pushed++;
            end else begin
                step(1'b0, 1'b0, '0);
            end
            budget++;
        end
        chk("wrap_pushed", 1, pushed, 20);
        idle(400);
        chk("wrap_cnt", 1, ev_n[1], 20);
        for (int i = 0; i < 20 && i < ev_n[1]; i++)
            chk("wrap_ord", 1, 32'(ev_c[1][i]), 32'(mk(i + 60)));
        for (int i = 0; i + 1 < 20 && i + 1 < ev_n[1]; i++)
            chk("wrap_per", 1, ev_t[1][i + 1] - ev_t[1][i], 34);

        // Randomized traffic against the model
        do_reset();
        pulses = 0;
        for (int ph = 0; ph < 6; ph++) begin
            int p;
            p = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 60 : 3;
            for (int i = 0; i < 500; i++) begin
                bit v;
                v = ($urandom_range(0, 99) < p);
                step(1'b0, v, 23'($urandom));
                if (o_en[0] === 1'b1) pulses++;
            end
            if (ph == 3) step(1'b1, 1'b0, '0);
        end
        chk("rand_activity", 0, 32'(pulses > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_cmd_queue.md
IIC_CMD_QUEUE -- requirements
Module: iic_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of command FIFO entries (power of two, 2..64).
REQ-002 Parameter: XFER_CYCLES, default 32, cycles reserved for one downstream write transaction after the enable pulse.
REQ-003 Parameter: GAP_CYCLES, default 4, idle cycles inserted between consecutive transactions (0 allowed).
REQ-004 Port: sys_clk  in  1  system clock, the same clock as the downstream IIC write stage.
REQ-005 Port: sys_reset  in  1  synchronous, active-high reset.
REQ-006 Port: cmd_valid  in  1  the producer offers a command.
REQ-007 Port: cmd_ready  out  1  the queue can accept a command.
REQ-008 Port: cmd_dev_addr  in  7  7-bit target device address.
REQ-009 Port: cmd_reg_addr  in  8  target register address.
REQ-010 Port: cmd_data  in  8  register write data.
REQ-011 Port: iic_send_en  out  1  one-cycle start pulse to the IIC write stage.
REQ-012 Port: iic_device_addr  out  7  device address to the write stage.
REQ-013 Port: iic_send_addr  out  8  register address to the write stage.
REQ-014 Port: iic_send_data  out  8  data byte to the write stage.
REQ-015 Port: busy  out  1  the FIFO is non-empty or a transaction or gap is in progress.
REQ-016 Port: fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 Port: overflow  out  1  sticky flag for a rejected push (see Configuration).

Function
REQ-018 The queue SHALL accept a command on every rising edge where cmd_valid && cmd_ready, storing {dev, reg, data} at the FIFO tail.
REQ-019 cmd_ready SHALL be the registered value of (fifo_level < DEPTH) and SHALL not depend combinationally on cmd_valid or on a pop.
REQ-020 When a push and a pop occur on the same edge, fifo_level SHALL be unchanged and both operations SHALL take effect.
REQ-021 The FSM states SHALL be S_IDLE, S_ISSUE, S_WAIT and S_GAP.
REQ-022 S_IDLE with fifo_level>0 SHALL transition to S_ISSUE on the next edge; on that edge the FIFO head SHALL be latched into iic_device_addr/iic_send_addr/iic_send_data and popped.
REQ-023 iic_send_en SHALL be 1 exactly while the state is S_ISSUE (one cycle); S_ISSUE SHALL always go to S_WAIT.
REQ-024 S_WAIT SHALL last exactly XFER_CYCLES cycles, then go to S_GAP, or to S_IDLE when GAP_CYCLES=0.
REQ-025 S_GAP SHALL last exactly GAP_CYCLES cycles, then go to S_IDLE.
REQ-026 Command outputs SHALL hold stable from latch until the next latch and SHALL never change during S_WAIT or S_GAP.
REQ-027 The enable-to-enable period for back-to-back commands SHALL be 1+XFER_CYCLES+GAP_CYCLES+1 cycles (38 with the defaults).
REQ-028 First-command latency SHALL be: push accepted at edge N -> iic_send_en high in the cycle after edge N+2.
REQ-029 The FIFO read and write pointers SHALL wrap modulo DEPTH with no entry lost or duplicated.
REQ-030 A push attempted while cmd_ready=0 SHALL be discarded without changing FIFO contents.

Reset
REQ-031 On sys_reset: state=S_IDLE, FIFO empty, fifo_level=0, cmd_ready=1, iic_send_en=0, iic_device_addr=0, iic_send_addr=0, iic_send_data=0, busy=0, overflow=0.
REQ-032 Reset asserted mid-transaction SHALL abort it, discard all queued commands and produce no further iic_send_en pulse.

Configuration
REQ-033 Macro IIC_CMD_QUEUE_OVF_FLAG_EN defined: overflow SHALL be set on any edge with cmd_valid=1 && cmd_ready=0 and SHALL clear only on sys_reset.
REQ-034 Macro IIC_CMD_QUEUE_OVF_FLAG_EN undefined: overflow SHALL be constant 0 and no overflow logic SHALL be synthesized.

Verification
REQ-035 Single push {0x50,0x12,0xA5} at edge 0 -> iic_send_en high for one cycle after edge 2, with outputs 0x50/0x12/0xA5; busy drops 37 cycles later.
REQ-036 Three back-to-back pushes -> three iic_send_en pulses 38 cycles apart, in push order, with outputs stable between pulses.
REQ-037 Push 10 commands (DEPTH=8) while the queue drains -> cmd_ready drops at level 8; with the macro defined overflow=1 after the rejected push, otherwise 0; every accepted command is issued in order.
REQ-038 A push and a pop on the same edge at fifo_level=3 -> fifo_level stays 3.
REQ-039 sys_reset asserted during S_WAIT with 2 commands queued -> all outputs take their reset values on the next cycle and no further pulses occur.
REQ-040 GAP_CYCLES=0 -> period 34 cycles; 20 pushes exercise pointer wrap, and the issue order matches the push order.
